// File: rtl/period_meter_pkg.sv
// ---------------------------------------------------------------------------
// period_meter_pkg
// Shared definitions for the period meter: FSM state encoding and the
// default counter width / synchronizer depth used by period_meter and
// edge_sync.
// ---------------------------------------------------------------------------
package period_meter_pkg;

  localparam int PM_CNT_W_DEFAULT       = 12;
  localparam int PM_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } pm_state_e;

endpackage

// File: rtl/period_meter_edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous level into the clk_in domain through a flop chain
// and flags its rising edges.
//
// Ports:
//   clk_in    in   sampling clock, rising edge
//   rst       in   asynchronous active-high reset, clears the whole chain
//   async_in  in   level to synchronize (asynchronous to clk_in)
//   sync_out  out  synchronized level (last stage of the chain)
//   rise      out  combinational strobe: sync_out high, previous sample low
// ---------------------------------------------------------------------------
module edge_sync #(
  parameter int STAGES = period_meter_pkg::PM_SYNC_STAGES_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
// Measures the rising-to-rising period of a slow asynchronous signal in
// clk_in cycles. A period with no edge for 2^CNT_W-1 cycles flags timeout.
//
// Ports:
//   clk_in        in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   meas_en       in   measurement enable (clk_in domain)
//   sig_in        in   signal to measure (asynchronous)
//   period        out  last measured period in clk_in cycles
//   period_valid  out  one-cycle pulse when period updates
//   high_time     out  cycles sync level was high in the measured period
//                      (present only when PERIOD_METER_DUTY_EN is defined)
//   timeout       out  no rising edge within 2^CNT_W-1 cycles
//
// Build option: PERIOD_METER_DUTY_EN adds the high_time output and counter.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | disabled, counter parked at 1
// ST_ARM     | enabled, waiting for a reference edge (no result on it)
// ST_MEASURE | counting cycles since the last edge; next edge gives period
// ---------------------------------------------------------------------------
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = PM_CNT_W_DEFAULT,
  parameter int SYNC_STAGES = PM_SYNC_STAGES_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             meas_en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
`ifdef PERIOD_METER_DUTY_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             sync_lvl;
  logic             rise;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (sig_in),
    .sync_out (sync_lvl),
    .rise     (rise)
  );

  // meas_en low outranks everything, including an edge on the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!meas_en) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = CNT_ONE;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // an edge on the saturation cycle still counts as a measurement
          if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = CNT_ONE;
            state_d   = ST_ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ONE;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             ref_edge;

  // The edge cycle itself has the synchronized level high, so a fresh
  // window starts at 1.
  assign ref_edge = meas_en & rise & ((state_q == ST_ARM) | (state_q == ST_MEASURE));

  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (ref_edge) begin
      hcnt_d = CNT_ONE;
    end else if (meas_en && (state_q == ST_MEASURE) && sync_lvl && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
    if (valid_d) begin
      high_d = hcnt_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign high_time = high_q;
`else
  logic unused_sync_lvl;
  assign unused_sync_lvl = sync_lvl;
`endif

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of period counter and results.
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (min 2): synchronizer depth on sig_in.
REQ-003 SHALL have port clk_in  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port meas_en  input  1  measurement enable, synchronous to clk_in.
REQ-006 SHALL have port sig_in  input  1  divided clock to measure, asynchronous to clk_in.
REQ-007 SHALL have port period  output  CNT_W  last measured rising-to-rising period, in clk_in cycles.
REQ-008 SHALL have port period_valid  output  1  one-cycle pulse when period updates.
REQ-009 SHALL have port timeout  output  1  no rising edge seen within 2^CNT_W-1 cycles.

Function
REQ-010 SHALL pass sig_in through SYNC_STAGES flops, then detect a rising edge (sync_q=1, previous=0); the edge strobe is internal.
REQ-011 SHALL implement states IDLE, ARM and MEASURE.
REQ-012 IDLE: SHALL hold cnt=1. SHALL go to ARM when meas_en=1.
REQ-013 ARM: SHALL wait for the first edge strobe, then set cnt=1 and go to MEASURE. No period_valid is produced on this first edge.
REQ-014 MEASURE: SHALL increment cnt by 1 each cycle.
REQ-015 MEASURE, on edge strobe: SHALL register period<=cnt, pulse period_valid for 1 cycle, clear timeout, set cnt=1, and stay in MEASURE.
REQ-016 A signal with period P cycles SHALL give period=P. period_valid SHALL assert on the cycle after the edge strobe (SYNC_STAGES+1 cycles after the sig_in rise at the clk_in edge).
REQ-017 Saturation: when cnt reaches 2^CNT_W-1 in MEASURE without an edge, SHALL set timeout=1, produce no period_valid, and return to ARM; period SHALL hold its old value.
REQ-018 Edge strobe on the same cycle cnt saturates: the edge SHALL win (measurement per REQ-015); timeout SHALL NOT set.
REQ-019 meas_en low in any state: SHALL go to IDLE on the next cycle. Any in-flight measurement SHALL be discarded. period and timeout SHALL hold their values.
REQ-020 Any state except IDLE with meas_en low and an edge strobe on the same cycle: SHALL go to IDLE, with no period_valid.
REQ-021 Minimum measurable period SHALL be 2 cycles (sig_in high 1 cycle, low 1 cycle, as sampled).

Reset
REQ-022 Asserting rst SHALL immediately force: state=IDLE, cnt=1, period=0, period_valid=0, timeout=0, all synchronizer flops=0.
REQ-023 Reset asserted mid-measurement SHALL discard the measurement. After deassertion, a fresh ARM SHALL be required before the next period_valid.

Configuration
REQ-024 Macro PERIOD_METER_DUTY_EN SHALL, when defined, add output high_time (CNT_W): clk_in cycles sync_q was high within the measured period. It SHALL be registered together with period and saturate at 2^CNT_W-1.
REQ-025 Without PERIOD_METER_DUTY_EN, the high_time port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-026 The shared package SHALL hold the state enumeration typedef (IDLE/ARM/MEASURE), the default CNT_W value 12, and the default SYNC_STAGES value 2.
REQ-027 Synchronizer plus rising-edge detect SHALL be one sub-module, edge_sync (inputs: clk_in, rst, async_in; outputs: sync_out, rise). period_meter SHALL instantiate it once.

Verification
REQ-028 Pattern: meas_en=1, sig_in square wave 5 high/5 low cycles -> first period_valid after the 2nd rising edge; period=10 on every pulse; timeout=0.
REQ-029 Pattern: sig_in 1 high/1 low -> period=2 on every pulse. With PERIOD_METER_DUTY_EN: high_time=1.
REQ-030 Pattern: sig_in held low for 5000 cycles after ARM edge -> timeout=1 at cnt=4095, no period_valid, period unchanged. The next two edges 8 cycles apart -> period=8, timeout=0.
REQ-031 Pattern: meas_en dropped 3 cycles before an expected edge -> no period_valid. Re-enabling -> first result only after ARM edge plus one full period.
REQ-032 Pattern: rst pulsed asynchronously mid-period (between clk_in edges) -> outputs 0 immediately; the next valid result equals the true period (e.g. 12), not a partial count.
REQ-033 Pattern: PERIOD_METER_DUTY_EN defined, sig_in 3 high/9 low -> period=12, high_time=3.
